fp_addsub: RTL and testbench

FP_ADDSUB -- requirements
Module: fp_addsub

---
 rtl/fp_addsub.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_fp_addsub.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fp_addsub.sv
// rtl/fp_addsub.sv - multi-cycle IEEE-style FP adder/subtractor; define FP_ADDSUB_FTZ_EN to flush subnormals to zero
module fp_addsub #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   op,
    input  logic [EXP_W+MAN_W:0]   input_a,
    input  logic                   input_a_stb,
    output logic                   input_a_ack,
    input  logic [EXP_W+MAN_W:0]   input_b,
    input  logic                   input_b_stb,
    output logic                   input_b_ack,
    output logic [EXP_W+MAN_W:0]   output_z,
    output logic                   output_z_stb,
    input  logic                   ack_output,
    output logic [3:0]             flags,
    output logic                   idle_status
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int MW = MAN_W + 4;   // hidden bit, fraction, guard, round, sticky
    localparam int EW = EXP_W + 2;   // signed unbiased exponent with headroom

    localparam logic signed [EW-1:0] E_ONE     = {{(EW-1){1'b0}}, 1'b1};
    localparam logic signed [EW-1:0] BIAS      = {3'b000, {(EXP_W-1){1'b1}}};
    localparam logic signed [EW-1:0] EMIN      = E_ONE - BIAS;
    localparam logic signed [EW-1:0] ALIGN_LIM = EW'(MAN_W + 3);
    localparam logic [MAN_W:0]       KEEP_ONE  = {{MAN_W{1'b0}}, 1'b1};
    localparam logic [W-1:0]         QNAN      = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [3:0] {
        IDLE, GET_A, GET_B, UNPACK, SPECIAL, ALIGN, ADD_0, ADD_1,
        NORM_1, NORM_2, ROUND, PACK, PUT_Z
    } state_t;

    state_t                 state;
    logic [W-1:0]           a_reg, b_reg;
    logic                   op_reg;
    logic                   a_s, b_s, z_s;
    logic signed [EW-1:0]   a_e, b_e, z_e;
    logic [MW-1:0]          a_m, b_m;
    logic [MW:0]            z_m;
    logic                   z_inexact;

    logic [EXP_W-1:0]       a_exp, b_exp;
    logic [MAN_W-1:0]       a_frac, b_frac;
    logic                   a_nan, b_nan, a_inf, b_inf, a_sub, b_sub, a_zero, b_zero;
    logic [3:0]             flush_flags;
    logic signed [EW-1:0]   ab_diff, ba_diff;
    logic [MAN_W:0]         z_keep;
    logic                   round_up;

    assign a_exp  = a_reg[W-2:MAN_W];
    assign b_exp  = b_reg[W-2:MAN_W];
    assign a_frac = a_reg[MAN_W-1:0];
    assign b_frac = b_reg[MAN_W-1:0];
    assign a_nan  = (&a_exp) && (|a_frac);
    assign b_nan  = (&b_exp) && (|b_frac);
    assign a_inf  = (&a_exp) && !(|a_frac);
    assign b_inf  = (&b_exp) && !(|b_frac);
    assign a_sub  = (a_exp == '0) && (|a_frac);
    assign b_sub  = (b_exp == '0) && (|b_frac);

`ifdef FP_ADDSUB_FTZ_EN
    // Subnormal operands count as zero; flushing one away is reported as underflow+inexact.
    assign a_zero      = (a_exp == '0);
    assign b_zero      = (b_exp == '0);
    assign flush_flags = {2'b00, {2{a_sub | b_sub}}};
`else
    assign a_zero      = (a_exp == '0) && (a_frac == '0);
    assign b_zero      = (b_exp == '0) && (b_frac == '0);
    assign flush_flags = 4'b0000;
`endif

    assign ab_diff  = a_e - b_e;
    assign ba_diff  = b_e - a_e;
    assign z_keep   = z_m[MW-1:3];
    assign round_up = z_m[2] & (z_m[1] | z_m[0] | z_m[3]);

    // Operation sequencer and datapath: handshake, unpack, align, add, normalise, round, pack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            input_a_ack  <= 1'b0;
            input_b_ack  <= 1'b0;
            output_z_stb <= 1'b0;
            output_z     <= '0;
            flags        <= 4'b0000;
            idle_status  <= 1'b1;
            a_reg        <= '0;
            b_reg        <= '0;
            op_reg       <= 1'b0;
            a_s          <= 1'b0;
            b_s          <= 1'b0;
            z_s          <= 1'b0;
            a_e          <= '0;
            b_e          <= '0;
            z_e          <= '0;
            a_m          <= '0;
            b_m          <= '0;
            z_m          <= '0;
            z_inexact    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= GET_A;
                        input_a_ack <= 1'b1;
                        idle_status <= 1'b0;
                    end
                end
                GET_A: begin
                    if (input_a_ack && input_a_stb) begin
                        a_reg       <= input_a;
                        input_a_ack <= 1'b0;
                        input_b_ack <= 1'b1;
                        state       <= GET_B;
                    end
                end
                GET_B: begin
                    if (input_b_ack && input_b_stb) begin
                        b_reg       <= input_b;
                        op_reg      <= op;
                        input_b_ack <= 1'b0;
                        state       <= UNPACK;
                    end
                end
                UNPACK: begin
                    a_m   <= {1'b0, a_frac, 3'b000};
                    b_m   <= {1'b0, b_frac, 3'b000};
                    a_e   <= $signed({2'b00, a_exp}) - BIAS;
                    b_e   <= $signed({2'b00, b_exp}) - BIAS;
                    a_s   <= a_reg[W-1];
                    b_s   <= b_reg[W-1] ^ op_reg;
                    state <= SPECIAL;
                end
                SPECIAL: begin
                    if (a_nan || b_nan || (a_inf && b_inf && (a_s != b_s))) begin
                        output_z <= QNAN;
                        flags    <= 4'b1000;
                    end else if (a_inf) begin
                        output_z <= {a_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        flags    <= 4'b0000;
                    end else if (b_inf) begin
                        output_z <= {b_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        flags    <= 4'b0000;
                    end else if (a_zero && b_zero) begin
                        output_z <= {a_s & b_s, {(W-1){1'b0}}};
                        flags    <= flush_flags;
                    end else if (a_zero) begin
                        output_z <= {b_s, b_reg[W-2:0]};
                        flags    <= flush_flags;
                    end else if (b_zero) begin
                        output_z <= a_reg;
                        flags    <= flush_flags;
                    end
                    if (a_nan || b_nan || a_inf || b_inf || a_zero || b_zero) begin
                        output_z_stb <= 1'b1;
                        state        <= PUT_Z;
                    end else begin
                        // Subnormals share the minimum exponent and have no hidden bit.
                        if (a_sub) a_e <= EMIN;
                        else       a_m[MW-1] <= 1'b1;
                        if (b_sub) b_e <= EMIN;
                        else       b_m[MW-1] <= 1'b1;
                        state <= ALIGN;
                    end
                end
                ALIGN: begin
                    if (a_e > b_e) begin
                        if (ab_diff > ALIGN_LIM) begin
                            b_m <= {{(MW-1){1'b0}}, |b_m};
                            b_e <= a_e;
                        end else begin
                            b_m <= {1'b0, b_m[MW-1:2], b_m[1] | b_m[0]};
                            b_e <= b_e + E_ONE;
                        end
                    end else if (b_e > a_e) begin
                        if (ba_diff > ALIGN_LIM) begin
                            a_m <= {{(MW-1){1'b0}}, |a_m};
                            a_e <= b_e;
                        end else begin
                            a_m <= {1'b0, a_m[MW-1:2], a_m[1] | a_m[0]};
                            a_e <= a_e + E_ONE;
                        end
                    end else begin
                        state <= ADD_0;
                    end
                end
                ADD_0: begin
                    z_e <= a_e;
                    if (a_s == b_s) begin
                        z_m <= {1'b0, a_m} + {1'b0, b_m};
                        z_s <= a_s;
                    end else if (a_m >= b_m) begin
                        z_m <= {1'b0, a_m - b_m};
                        z_s <= a_s;
                    end else begin
                        z_m <= {1'b0, b_m - a_m};
                        z_s <= b_s;
                    end
                    state <= ADD_1;
                end
                ADD_1: begin
                    // An exact zero skips normalisation so it cannot walk the exponent down.
                    if (z_m == '0) begin
                        state <= PACK;
                    end else begin
                        if (z_m[MW]) begin
                            z_m <= {1'b0, z_m[MW:2], z_m[1] | z_m[0]};
                            z_e <= z_e + E_ONE;
                        end
                        state <= NORM_1;
                    end
                end
                NORM_1: begin
                    if (!z_m[MW-1] && (z_e > EMIN)) begin
                        z_m <= {z_m[MW-1:0], 1'b0};
                        z_e <= z_e - E_ONE;
                    end else begin
                        state <= NORM_2;
                    end
                end
                NORM_2: begin
`ifdef FP_ADDSUB_FTZ_EN
                    state <= ROUND;
`else
                    if (z_e < EMIN) begin
                        z_m <= {1'b0, z_m[MW:2], z_m[1] | z_m[0]};
                        z_e <= z_e + E_ONE;
                    end else begin
                        state <= ROUND;
                    end
`endif
                end
                ROUND: begin
                    z_inexact <= |z_m[2:0];
                    if (round_up) begin
                        if (&z_keep) begin
                            z_m[MW-1:3] <= {1'b1, {MAN_W{1'b0}}};
                            z_e         <= z_e + E_ONE;
                        end else begin
                            z_m[MW-1:3] <= z_keep + KEEP_ONE;
                        end
                    end
                    state <= PACK;
                end
                PACK: begin
                    if (z_m == '0) begin
                        output_z <= '0;
                        flags    <= 4'b0000;
                    end else if (z_e > BIAS) begin
                        output_z <= {z_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        flags    <= 4'b0101;
                    end else if (!z_m[MW-1]) begin
`ifdef FP_ADDSUB_FTZ_EN
                        output_z <= {z_s, {(W-1){1'b0}}};
                        flags    <= 4'b0011;
`else
                        output_z <= {z_s, {EXP_W{1'b0}}, z_m[MW-2:3]};
                        flags    <= {2'b00, z_inexact, z_inexact};
`endif
                    end else begin
                        output_z <= {z_s, EXP_W'(z_e + BIAS), z_m[MW-2:3]};
                        flags    <= {3'b000, z_inexact};
                    end
                    output_z_stb <= 1'b1;
                    state        <= PUT_Z;
                end
                PUT_Z: begin
                    if (output_z_stb && ack_output) begin
                        output_z_stb <= 1'b0;
                        idle_status  <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_addsub.sv
// tb/tb_fp_addsub.sv - scoreboard bench for fp_addsub with directed single-precision vectors
module tb_fp_addsub;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        op;
    logic [31:0] input_a;
    logic        input_a_stb;
    logic        input_a_ack;
    logic [31:0] input_b;
    logic        input_b_stb;
    logic        input_b_ack;
    logic [31:0] output_z;
    logic        output_z_stb;
    logic        ack_output;
    logic [3:0]  flags;
    logic        idle_status;

    int compared   = 0;
    int mismatched = 0;

    logic [35:0] exp_q[$];
    string       name_q[$];

    always #5 clk = ~clk;

    fp_addsub dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .op           (op),
        .input_a      (input_a),
        .input_a_stb  (input_a_stb),
        .input_a_ack  (input_a_ack),
        .input_b      (input_b),
        .input_b_stb  (input_b_stb),
        .input_b_ack  (input_b_ack),
        .output_z     (output_z),
        .output_z_stb (output_z_stb),
        .ack_output   (ack_output),
        .flags        (flags),
        .idle_status  (idle_status)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    // Monitor: every accepted result is compared against the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && output_z_stb && ack_output) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_result: got %h flags %b, expected no result", output_z, flags);
            end else begin
                check(name_q.pop_front(), {28'd0, output_z, flags}, {28'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b, input logic o,
                          input logic [31:0] ez, input logic [3:0] ef, input int b_delay, input int hold);
        int lat;
        input_a     = a;
        input_b     = b;
        op          = o;
        input_a_stb = 1'b1;
        input_b_stb = (b_delay == 0);
        ack_output  = (hold == 0);
        exp_q.push_back({ez, ef});
        name_q.push_back(name);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        if (b_delay > 0) begin
            repeat (b_delay) begin
                @(negedge clk);
                lat++;
            end
            check({name, "_b_ack_wait"}, 64'(input_b_ack), 64'd1);
            input_b_stb = 1'b1;
        end
        while (!output_z_stb && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        if (!output_z_stb) begin
            compared++;
            mismatched++;
            $display("FAIL %s_timeout: got no output_z_stb after %0d cycles, expected one", name, lat);
            exp_q.delete();
            name_q.delete();
            ack_output = 1'b1;
        end else begin
            if (b_delay == 0) begin
                compared++;
                if (lat > 62) begin
                    mismatched++;
                    $display("FAIL %s_latency: got %0d cycles, expected <= 62", name, lat);
                end
            end
            if (hold > 0) begin
                repeat (hold) @(negedge clk);
                check({name, "_held_stb"}, 64'(output_z_stb), 64'd1);
                check({name, "_held_z"}, {28'd0, output_z, flags}, {28'd0, ez, ef});
                @(posedge clk);
                #1 ack_output = 1'b1;
            end
            @(negedge clk);
            @(negedge clk);
            compared++;
            if (exp_q.size() != 0) begin
                mismatched++;
                $display("FAIL %s_consumed: got %0d pending results, expected 0", name, exp_q.size());
                exp_q.delete();
                name_q.delete();
            end
            check({name, "_idle"}, 64'(idle_status), 64'd1);
        end
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        op          = 1'b0;
        input_a     = '0;
        input_b     = '0;
        input_a_stb = 1'b0;
        input_b_stb = 1'b0;
        ack_output  = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_handshake", {60'd0, input_a_ack, input_b_ack, output_z_stb, idle_status}, 64'b0001);
        check("reset_result", {28'd0, output_z, flags}, 64'd0);
        @(posedge clk);
        #2 rst = 1'b0;

        run_op("add_1_2",        32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000, 0, 0);
        run_op("sub_equal",      32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000, 0, 0);
        run_op("inf_plus_ninf",  32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000, 0, 0);
        run_op("overflow",       32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101, 0, 0);
`ifdef FP_ADDSUB_FTZ_EN
        run_op("subnormal_add",  32'h00000001, 32'h00000001, 1'b0, 32'h00000000, 4'b0011, 0, 0);
        run_op("far_sticky",     32'h3F800000, 32'h00000001, 1'b0, 32'h3F800000, 4'b0011, 0, 0);
        run_op("sub_to_subnorm", 32'h00800000, 32'h00000001, 1'b1, 32'h00800000, 4'b0011, 0, 0);
        run_op("tiny_diff",      32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0011, 0, 0);
`else
        run_op("subnormal_add",  32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 4'b0000, 0, 0);
        run_op("far_sticky",     32'h3F800000, 32'h00000001, 1'b0, 32'h3F800000, 4'b0001, 0, 0);
        run_op("sub_to_subnorm", 32'h00800000, 32'h00000001, 1'b1, 32'h007FFFFF, 4'b0000, 0, 0);
        run_op("tiny_diff",      32'h00800001, 32'h00800000, 1'b1, 32'h00000001, 4'b0000, 0, 0);
`endif
        run_op("nan_in",         32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000, 0, 0);
        run_op("neg_zeros",      32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000, 0, 0);
        run_op("mixed_zeros",    32'h80000000, 32'h00000000, 1'b0, 32'h00000000, 4'b0000, 0, 0);
        run_op("zero_minus_one", 32'h00000000, 32'h3F800000, 1'b1, 32'hBF800000, 4'b0000, 0, 0);
        run_op("tie_even_down",  32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001, 0, 0);
        run_op("tie_odd_up",     32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001, 0, 0);
        run_op("round_exp_carry",32'h3FFFFFFF, 32'h33800000, 1'b0, 32'h40000000, 4'b0001, 0, 0);
        run_op("norm_left",      32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000, 4'b0000, 4, 0);
        run_op("inf_sub_inf",    32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000, 0, 0);
        run_op("one_minus_inf",  32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 4'b0000, 0, 3);
        run_op("mixed_sign",     32'hC0000000, 32'h3F800000, 1'b0, 32'hBF800000, 4'b0000, 0, 2);

        input_a     = 32'h3F800000;
        input_b     = 32'h33800000;
        op          = 1'b0;
        input_a_stb = 1'b1;
        input_b_stb = 1'b1;
        ack_output  = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("mid_align_busy", 64'(idle_status), 64'd0);
        #2 rst = 1'b1;
        #1;
        check("rst_align_handshake", {60'd0, input_a_ack, input_b_ack, output_z_stb, idle_status}, 64'b0001);
        check("rst_align_result", {28'd0, output_z, flags}, 64'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        run_op("after_reset",    32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
